// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: payment FSM encoding, coin values and
// 3-digit BCD arithmetic helpers, also used by the billing block.
package wm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADD    = 3'd1,
    ST_CHK    = 3'd2,
    ST_SUB    = 3'd3,
    ST_ACK    = 3'd4,
    ST_REFUND = 3'd5
  } wm_state_t;

  localparam logic [11:0] COIN1    = 12'h001;
  localparam logic [11:0] COIN5    = 12'h005;
  localparam logic [11:0] COIN10   = 12'h010;
  localparam logic [11:0] BCD_ZERO = 12'h000;

  function automatic logic bcd_valid(input logic [11:0] a);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ok = ok & (a[i*4 +: 4] <= 4'd9);
    end
    return ok;
  endfunction

  // Returns {decimal carry out, 3-digit sum}.
  function automatic logic [12:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] s;
    logic        c;
    logic [4:0]  t;
    s = 12'h000;
    c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0000, c};
      if (t > 5'd9) begin
        t = t + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[i*4 +: 4] = t[3:0];
    end
    return {c, s};
  endfunction

  // a - b; the caller guarantees a >= b.
  function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] d;
    logic        br;
    logic [4:0]  t;
    d  = 12'h000;
    br = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t = {1'b0, a[i*4 +: 4]} - {1'b0, b[i*4 +: 4]} - {4'b0000, br};
      if (t[4]) begin
        t  = t + 5'd10;
        br = 1'b1;
      end else begin
        br = 1'b0;
      end
      d[i*4 +: 4] = t[3:0];
    end
    return d;
  endfunction

  function automatic logic bcd_lt(input logic [11:0] a, input logic [11:0] b);
    logic lt;
    logic done;
    lt   = 1'b0;
    done = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (!done && (a[i*4 +: 4] != b[i*4 +: 4])) begin
        lt   = (a[i*4 +: 4] < b[i*4 +: 4]);
        done = 1'b1;
      end else begin
        lt = lt;
      end
    end
    return lt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, stable-count debouncer
// and a one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned   CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          pulse_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, count how long the input differs from the accepted level, accept after DEB_CYCLES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      pulse_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      pulse_r <= 1'b0;
      if (sync2_r != stable_r) begin
        if (cnt_r == CNT_LAST) begin
          stable_r <= sync2_r;
          cnt_r    <= {CW{1'b0}};
          pulse_r  <= sync2_r;
        end else begin
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/coin_wallet.sv
// Payment front end: debounced coin/refund buttons, saturating BCD balance and
// a 4-phase charge handshake towards the billing stage.
module coin_wallet
  import wm_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 2_000_000,
  parameter logic [11:0] BAL_MAX    = 12'h999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        on,
  input  logic        btn_c1,
  input  logic        btn_c5,
  input  logic        btn_c10,
  input  logic        btn_refund,
  input  logic        chg_req,
  input  logic [11:0] chg_amt,
  output logic [11:0] bal,
  output logic        chg_ok,
  output logic        chg_nak,
  output logic        refund_pulse,
  output logic [11:0] refund_amt,
  output logic        busy
);

  // Bit order of the press/pending vectors: 0 = c1, 1 = c5, 2 = c10, 3 = refund.
  logic [3:0]  raw_s;
  logic [3:0]  press_s;
  logic [3:0]  pend_r;
  logic [3:0]  clr_s;

  wm_state_t   state_r, state_nxt_s;
  logic [11:0] bal_r, bal_nxt_s;
  logic [11:0] amt_r, amt_nxt_s;
  logic [11:0] coin_r, coin_nxt_s;
  logic [2:0]  csel_r, csel_nxt_s;
  logic [11:0] ramt_r, ramt_nxt_s;
  logic        ok_r, ok_nxt_s;
  logic        nak_r, nak_nxt_s;
  logic        rpulse_r, rpulse_nxt_s;
  logic        armed_r, armed_nxt_s;
  logic        busy_r;
  logic [12:0] sum_s;
  logic [11:0] sat_s;

  assign raw_s = {btn_refund, btn_c10, btn_c5, btn_c1};

  for (genvar g = 0; g < 4; g++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (raw_s[g]),
      .pulse (press_s[g])
    );
  end

  assign sum_s = bcd_add(bal_r, coin_r);
  assign sat_s = (sum_s[12] || bcd_lt(BAL_MAX, sum_s[11:0])) ? BAL_MAX : sum_s[11:0];

  // Pending flags: a press is remembered until serviced; power-off discards everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r <= 4'b0000;
    end else if (!on) begin
      pend_r <= 4'b0000;
    end else begin
      pend_r <= (pend_r & ~clr_s) | press_s;
    end
  end

  // Next-state and next-output logic of the payment FSM.
  always_comb begin
    state_nxt_s  = state_r;
    bal_nxt_s    = bal_r;
    amt_nxt_s    = amt_r;
    coin_nxt_s   = coin_r;
    csel_nxt_s   = csel_r;
    ramt_nxt_s   = ramt_r;
    ok_nxt_s     = ok_r;
    nak_nxt_s    = nak_r;
    rpulse_nxt_s = 1'b0;
    armed_nxt_s  = armed_r;
    clr_s        = 4'b0000;
    case (state_r)
      ST_IDLE: begin
        // Charges must see chg_req low here before a new rise is accepted.
        if (chg_req && armed_r) begin
          amt_nxt_s   = chg_amt;
          armed_nxt_s = 1'b0;
          state_nxt_s = ST_CHK;
        end else if (pend_r[3]) begin
          armed_nxt_s  = !chg_req ? 1'b1 : armed_r;
          ramt_nxt_s   = bal_r;
          bal_nxt_s    = BCD_ZERO;
          rpulse_nxt_s = 1'b1;
          state_nxt_s  = ST_REFUND;
        end else if (pend_r[2]) begin
          armed_nxt_s = !chg_req ? 1'b1 : armed_r;
          coin_nxt_s  = COIN10;
          csel_nxt_s  = 3'b100;
          state_nxt_s = ST_ADD;
        end else if (pend_r[1]) begin
          armed_nxt_s = !chg_req ? 1'b1 : armed_r;
          coin_nxt_s  = COIN5;
          csel_nxt_s  = 3'b010;
          state_nxt_s = ST_ADD;
        end else if (pend_r[0]) begin
          armed_nxt_s = !chg_req ? 1'b1 : armed_r;
          coin_nxt_s  = COIN1;
          csel_nxt_s  = 3'b001;
          state_nxt_s = ST_ADD;
        end else begin
          armed_nxt_s = !chg_req ? 1'b1 : armed_r;
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        bal_nxt_s   = sat_s;
        clr_s       = {1'b0, csel_r};
        state_nxt_s = ST_IDLE;
      end
      ST_CHK: begin
        if (!on || !bcd_valid(amt_r) || bcd_lt(bal_r, amt_r)) begin
          nak_nxt_s   = 1'b1;
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_SUB;
        end
      end
      ST_SUB: begin
        bal_nxt_s   = bcd_sub(bal_r, amt_r);
        ok_nxt_s    = 1'b1;
        state_nxt_s = ST_ACK;
      end
      ST_ACK: begin
        if (!chg_req) begin
          ok_nxt_s    = 1'b0;
          nak_nxt_s   = 1'b0;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      ST_REFUND: begin
        clr_s       = 4'b1000;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        ok_nxt_s    = 1'b0;
        nak_nxt_s   = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      bal_r    <= BCD_ZERO;
      amt_r    <= BCD_ZERO;
      coin_r   <= BCD_ZERO;
      csel_r   <= 3'b000;
      ramt_r   <= BCD_ZERO;
      ok_r     <= 1'b0;
      nak_r    <= 1'b0;
      rpulse_r <= 1'b0;
      armed_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      bal_r    <= bal_nxt_s;
      amt_r    <= amt_nxt_s;
      coin_r   <= coin_nxt_s;
      csel_r   <= csel_nxt_s;
      ramt_r   <= ramt_nxt_s;
      ok_r     <= ok_nxt_s;
      nak_r    <= nak_nxt_s;
      rpulse_r <= rpulse_nxt_s;
      armed_r  <= armed_nxt_s;
      busy_r   <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bal          = bal_r;
  assign chg_ok       = ok_r;
  assign chg_nak      = nak_r;
  assign refund_pulse = rpulse_r;
  assign refund_amt   = ramt_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_coin_wallet.sv
// Self-checking bench for coin_wallet: directed scenarios plus random coin,
// charge, refund and power operations against a decimal-integer wallet model.
module tb_coin_wallet;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        on;
  logic        btn_c1, btn_c5, btn_c10, btn_refund;
  logic        chg_req;
  logic [11:0] chg_amt;
  logic [11:0] bal;
  logic        chg_ok, chg_nak, refund_pulse;
  logic [11:0] refund_amt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_bal = 0;
  int exp_ramt = 0;
  bit settled = 1'b0;

  always #5 clk = ~clk;

  coin_wallet #(.DEB_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst          (rst),
    .on           (on),
    .btn_c1       (btn_c1),
    .btn_c5       (btn_c5),
    .btn_c10      (btn_c10),
    .btn_refund   (btn_refund),
    .chg_req      (chg_req),
    .chg_amt      (chg_amt),
    .bal          (bal),
    .chg_ok       (chg_ok),
    .chg_nak      (chg_nak),
    .refund_pulse (refund_pulse),
    .refund_amt   (refund_amt),
    .busy         (busy)
  );

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic int bcd_int(input logic [11:0] a);
    return int'(a[11:8]) * 100 + int'(a[7:4]) * 10 + int'(a[3:0]);
  endfunction

  function automatic bit bcd_is_valid(input logic [11:0] a);
    return (a[11:8] <= 4'd9) && (a[7:4] <= 4'd9) && (a[3:0] <= 4'd9);
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {11'd0, act}, {11'd0, exp});
  endtask

  // Whenever nothing is in flight the outputs must show the model's resting state.
  always @(negedge clk) begin
    if (settled) begin
      chk("idle_bal", bal, to_bcd(exp_bal));
      chk("idle_ramt", refund_amt, to_bcd(exp_ramt));
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_ok", chg_ok, 1'b0);
      chk1("idle_nak", chg_nak, 1'b0);
      chk1("idle_pulse", refund_pulse, 1'b0);
    end
  end

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: btn_c1 = v;
      1: btn_c5 = v;
      2: btn_c10 = v;
      default: btn_refund = v;
    endcase
  endtask

  // idx 0/1/2 = coin 1/5/10, 3 = refund. Accepted press is serviced at fixed latency.
  task automatic press(input int idx);
    int v;
    int old;
    int nb;
    old = exp_bal;
    v = (idx == 0) ? 1 : (idx == 1) ? 5 : (idx == 2) ? 10 : 0;
    nb = (old + v > 999) ? 999 : old + v;
    settled = 1'b0;
    set_btn(idx, 1'b1);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 8) begin
        if (on && idx == 3) begin
          chk1("ref_pulse", refund_pulse, 1'b1);
          chk("ref_amt", refund_amt, to_bcd(old));
          chk("ref_bal", bal, 12'h000);
          chk1("ref_busy", busy, 1'b1);
        end else if (on) begin
          chk1("add_busy", busy, 1'b1);
          chk("add_bal_pre", bal, to_bcd(old));
        end else begin
          chk1("off_busy", busy, 1'b0);
          chk1("off_pulse", refund_pulse, 1'b0);
          chk("off_bal", bal, to_bcd(old));
        end
      end
      if (k == 9) begin
        chk1("p9_pulse", refund_pulse, 1'b0);
        chk1("p9_busy", busy, 1'b0);
        if (on && idx == 3) chk("ref_bal2", bal, 12'h000);
        else if (on) chk("add_bal", bal, to_bcd(nb));
        else chk("off_bal2", bal, to_bcd(old));
      end
      if (k == 10) set_btn(idx, 1'b0);
    end
    if (on && idx == 3) begin
      exp_ramt = old;
      exp_bal = 0;
    end else if (on) begin
      exp_bal = nb;
    end
    settled = 1'b1;
  endtask

  task automatic charge(input logic [11:0] amt);
    bit good;
    int hold;
    logic [11:0] nb;
    good = on && bcd_is_valid(amt) && (exp_bal >= bcd_int(amt));
    nb = good ? to_bcd(exp_bal - bcd_int(amt)) : to_bcd(exp_bal);
    settled = 1'b0;
    chg_amt = amt;
    chg_req = 1'b1;
    @(negedge clk);
    chk1("c1_busy", busy, 1'b1);
    chk1("c1_ok", chg_ok, 1'b0);
    chk1("c1_nak", chg_nak, 1'b0);
    @(negedge clk);
    chk1("c2_nak", chg_nak, !good);
    chk1("c2_ok", chg_ok, 1'b0);
    @(negedge clk);
    chk1("c3_ok", chg_ok, good);
    chk1("c3_nak", chg_nak, !good);
    chk("c3_bal", bal, nb);
    chg_amt = 12'($urandom);
    hold = $urandom_range(0, 3);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk1("hold_ok", chg_ok, good);
      chk1("hold_nak", chg_nak, !good);
    end
    chg_req = 1'b0;
    @(negedge clk);
    chk1("rel_ok", chg_ok, 1'b0);
    chk1("rel_nak", chg_nak, 1'b0);
    chk1("rel_busy", busy, 1'b0);
    if (good) exp_bal = exp_bal - bcd_int(amt);
    @(negedge clk);
    settled = 1'b1;
  endtask

  initial begin
    int old;
    int op;
    int m;
    logic [11:0] a;
    rst = 1'b0;
    on = 1'b0;
    btn_c1 = 1'b0;
    btn_c5 = 1'b0;
    btn_c10 = 1'b0;
    btn_refund = 1'b0;
    chg_req = 1'b0;
    chg_amt = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_bal", bal, 12'h000);
    chk("rst_ramt", refund_amt, 12'h000);
    chk1("rst_ok", chg_ok, 1'b0);
    chk1("rst_nak", chg_nak, 1'b0);
    chk1("rst_pulse", refund_pulse, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b1;
    on = 1'b1;
    repeat (3) @(negedge clk);
    settled = 1'b1;

    press(2); press(1); press(0);
    chk("bal_016", bal, 12'h016);
    charge(12'h009);
    chk("bal_007", bal, 12'h007);
    charge(12'h012);
    chk("bal_007_nak", bal, 12'h007);

    for (int i = 0; i < 98; i++) press(2);
    press(1);
    for (int i = 0; i < 3; i++) press(0);
    chk("bal_995", bal, 12'h995);
    press(2);
    chk("bal_sat", bal, 12'h999);
    press(3);
    chk("ramt_999", refund_amt, 12'h999);
    chk("bal_zero", bal, 12'h000);
    press(2);

    // Coin pending in the same cycle a charge is accepted: charge first, coin after.
    settled = 1'b0;
    old = exp_bal;
    btn_c5 = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 7) begin
        chg_amt = 12'h002;
        chg_req = 1'b1;
      end
      if (k == 10) begin
        chk1("mix_ok", chg_ok, 1'b1);
        chk("mix_bal_sub", bal, to_bcd(old - 2));
        chg_req = 1'b0;
        btn_c5 = 1'b0;
      end
      if (k == 11) chk1("mix_ok_low", chg_ok, 1'b0);
      if (k == 12) chk("mix_bal_mid", bal, to_bcd(old - 2));
      if (k == 13) chk("mix_bal_add", bal, to_bcd(old + 3));
    end
    exp_bal = old + 3;
    settled = 1'b1;
    chk("bal_013", bal, 12'h013);
    charge(12'h000);
    chk("bal_zero_chg", bal, 12'h013);

    // Reset while the charge acknowledge is being held.
    settled = 1'b0;
    chg_amt = 12'h001;
    chg_req = 1'b1;
    repeat (3) @(negedge clk);
    chk1("pre_rst_ok", chg_ok, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_bal", bal, 12'h000);
    chk("mid_rst_ramt", refund_amt, 12'h000);
    chk1("mid_rst_ok", chg_ok, 1'b0);
    chk1("mid_rst_nak", chg_nak, 1'b0);
    chk1("mid_rst_pulse", refund_pulse, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chg_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_bal = 0;
    exp_ramt = 0;
    repeat (3) @(negedge clk);
    settled = 1'b1;

    for (int n = 0; n < 90; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        press(op);
      end else if (op <= 6) begin
        m = $urandom_range(0, 3);
        case (m)
          0: a = to_bcd(int'($urandom_range(0, exp_bal)));
          1: a = to_bcd(int'($urandom_range(0, 999)));
          2: a = 12'h000;
          default: begin
            a = to_bcd(int'($urandom_range(0, 999)));
            a[7:4] = 4'($urandom_range(10, 15));
          end
        endcase
        charge(a);
      end else if (op == 7) begin
        press(3);
      end else begin
        on = ($urandom_range(0, 3) != 0);
      end
    end

    on = 1'b1;
    press(2);
    on = 1'b0;
    press(1);
    press(3);
    charge(12'h000);
    on = 1'b1;
    press(3);
    chk("final_bal", bal, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
